// File: rtl/acq_capture_sched.sv
// Capture scheduler for the two-channel acquisition front end.
// Qualifies a trigger, arbitrates round-robin, streams one record to RAM.
module acq_capture_sched #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int QUAL  = 4
) (
  input  logic          CLK_P,
  input  logic          RESET,
  input  logic [13:0]   PD_A,
  input  logic [13:0]   PD_B,
  input  logic          HAVE_A,
  input  logic          HAVE_B,
  input  logic [1:0]    CH_EN,
  input  logic          ARM,
  input  logic          ABORT,
  input  logic          ACK,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [13:0]   WR_DATA,
  output logic          BUSY,
  output logic          CAP_DONE,
  output logic          CAP_CH
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0]    QMAX  = 4'(QUAL);
  localparam logic [3:0]    QLAST = 4'(QUAL - 1);
  localparam logic [AW-1:0] AEND  = AW'(DEPTH - 1);

  logic [1:0]  state;
  logic [3:0]  qa;
  logic [3:0]  qb;
  logic        last;
  logic        sel;
  logic        term_a;
  logic        term_b;
  logic        hit_a;
  logic        hit_b;
  logic        trig;
  logic        win;
  logic [13:0] pd_win;
  logic [13:0] pd_sel;
  logic [3:0]  qa_nxt;
  logic [3:0]  qb_nxt;

  assign term_a = HAVE_A & CH_EN[0];
  assign term_b = HAVE_B & CH_EN[1];
  assign hit_a  = term_a && (qa == QLAST);
  assign hit_b  = term_b && (qb == QLAST);
  assign trig   = hit_a | hit_b;

  // On a tie the channel that did not win last time gets the record.
  assign win    = (hit_a && hit_b) ? ~last : hit_b;
  assign pd_win = win ? PD_B : PD_A;
  assign pd_sel = sel ? PD_B : PD_A;

  assign qa_nxt = !term_a ? 4'd0 :
                  (qa == QMAX) ? qa : qa + 4'd1;
  assign qb_nxt = !term_b ? 4'd0 :
                  (qb == QMAX) ? qb : qb + 4'd1;

  assign WR_EN    = (state == S_CAPT);
  assign BUSY     = (state == S_ARMED) || (state == S_CAPT);
  assign CAP_DONE = (state == S_DONE);

  always_ff @(posedge CLK_P) begin
    if (RESET) begin
      state   <= S_IDLE;
      qa      <= 4'd0;
      qb      <= 4'd0;
      last    <= 1'b1;
      sel     <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
      CAP_CH  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          qa <= 4'd0;
          qb <= 4'd0;
          if (ARM && !ABORT) state <= S_ARMED;
        end
        S_ARMED: begin
          if (ABORT) begin
            state <= S_IDLE;
            qa    <= 4'd0;
            qb    <= 4'd0;
          end else if (trig) begin
            state   <= S_CAPT;
            sel     <= win;
            last    <= win;
            CAP_CH  <= win;
            WR_ADDR <= '0;
            WR_DATA <= pd_win;
            qa      <= 4'd0;
            qb      <= 4'd0;
          end else begin
            qa <= qa_nxt;
            qb <= qb_nxt;
          end
        end
        S_CAPT: begin
          if (ABORT) begin
            state   <= S_IDLE;
            WR_ADDR <= '0;
          end else if (WR_ADDR == AEND) begin
            state   <= S_DONE;
            WR_ADDR <= '0;
          end else begin
            WR_ADDR <= WR_ADDR + 1'b1;
            WR_DATA <= pd_sel;
          end
        end
        S_DONE: begin
          if (ABORT || ACK) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_capture_sched.sv
// Scoreboard bench for acq_capture_sched, DEPTH = 8, QUAL = 4.
// Stimulus pushes expected RAM writes; a negedge monitor pops them.
module tb_acq_capture_sched;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int QUAL  = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [13:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [13:0]   pd_a;
  logic [13:0]   pd_b;
  logic          have_a;
  logic          have_b;
  logic [1:0]    ch_en;
  logic          arm_i;
  logic          abort_i;
  logic          ack_i;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [13:0]   wr_data;
  logic          busy;
  logic          cap_done;
  logic          cap_ch;

  int  checks = 0;
  int  errors = 0;
  int  ecount = 0;
  wr_t sb[$];

  acq_capture_sched #(.DEPTH(DEPTH), .AW(AW), .QUAL(QUAL)) dut (
    .CLK_P(clk), .RESET(rst),
    .PD_A(pd_a), .PD_B(pd_b),
    .HAVE_A(have_a), .HAVE_B(have_b),
    .CH_EN(ch_en), .ARM(arm_i),
    .ABORT(abort_i), .ACK(ack_i),
    .WR_EN(wr_en), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data), .BUSY(busy),
    .CAP_DONE(cap_done), .CAP_CH(cap_ch)
  );

  always #5 clk = ~clk;

  // Sample value presented at edge m (ramps are driven after each edge).
  function automatic logic [13:0] pda_at(input int m);
    return 14'(99 + m);
  endfunction

  function automatic logic [13:0] pdb_at(input int m);
    return 14'(8999 + m);
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ecount++;
      pd_a = pda_at(ecount + 1);
      pd_b = pdb_at(ecount + 1);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_rec(input bit ch, input int t, input int n);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      w.addr = AW'(k);
      w.data = ch ? pdb_at(t + k) : pda_at(t + k);
      sb.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      wr_t w;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d", wr_addr, wr_data);
      end else begin
        w = sb.pop_front();
        if (wr_addr !== w.addr || wr_data !== w.data) begin
          errors++;
          $display("FAIL ram_write: got addr %0d data %0d expected addr %0d data %0d",
                   wr_addr, wr_data, w.addr, w.data);
        end
      end
    end
  end

  task automatic do_arm();
    arm_i = 1'b1;
    tick(1);
    arm_i = 1'b0;
    chk("busy_after_arm", int'(busy), 1);
  endtask

  task automatic capture(input logic [1:0] en, input bit ha, input bit hb,
                         input bit exp_ch, input bit arm_busy);
    int c;
    ch_en = en;
    do_arm();
    have_a = ha;
    have_b = hb;
    c = ecount;
    expect_rec(exp_ch, c + QUAL, DEPTH);
    tick(QUAL - 1);
    chk("pre_trigger_wr_en", int'(wr_en), 0);
    tick(1);
    chk("first_write_en", int'(wr_en), 1);
    if (arm_busy) arm_i = 1'b1;
    tick(DEPTH);
    chk("done_flag", int'(cap_done), 1);
    chk("done_wr_en", int'(wr_en), 0);
    chk("done_busy", int'(busy), 0);
    chk("done_addr", int'(wr_addr), 0);
    chk("cap_ch", int'(cap_ch), int'(exp_ch));
    tick(2);
    chk("done_held", int'(cap_done), 1);
    chk("no_restart", int'(busy), 0);
    arm_i = 1'b0;
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    chk("ack_clears_done", int'(cap_done), 0);
    have_a = 1'b0;
    have_b = 1'b0;
    tick(1);
  endtask

  initial begin
    bit pat [8];
    int c;
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rst = 1'b1;
    pd_a = pda_at(1);
    pd_b = pdb_at(1);
    have_a = 1'b0;
    have_b = 1'b0;
    ch_en = 2'b00;
    arm_i = 1'b0;
    abort_i = 1'b0;
    ack_i = 1'b0;
    tick(2);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(cap_done), 0);
    chk("rst_cap_ch", int'(cap_ch), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    rst = 1'b0;
    tick(1);

    // Three ties after reset alternate A, B, A.
    capture(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    capture(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    capture(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);

    // Basic A capture.
    capture(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);

    // Qualification glitch 1,1,1,0,1,1,1,1.
    ch_en = 2'b01;
    do_arm();
    c = ecount;
    expect_rec(1'b0, c + 8, DEPTH);
    for (int i = 0; i < 8; i++) begin
      have_a = pat[i];
      tick(1);
      if (i == 6) chk("glitch_no_write", int'(wr_en), 0);
    end
    chk("glitch_first_write", int'(wr_en), 1);
    tick(DEPTH);
    chk("glitch_done", int'(cap_done), 1);
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    have_a = 1'b0;
    tick(1);

    // Disabled channel A: waits, then B triggers.
    ch_en = 2'b10;
    do_arm();
    have_a = 1'b1;
    tick(10);
    chk("disabled_busy", int'(busy), 1);
    chk("disabled_no_write", int'(wr_en), 0);
    have_b = 1'b1;
    c = ecount;
    expect_rec(1'b1, c + QUAL, DEPTH);
    tick(QUAL + DEPTH);
    chk("disabled_b_done", int'(cap_done), 1);
    chk("disabled_b_ch", int'(cap_ch), 1);
    ack_i = 1'b1;
    tick(1);
    ack_i = 1'b0;
    have_a = 1'b0;
    have_b = 1'b0;
    tick(1);

    // Abort a B record after write 3; next tie goes to A.
    ch_en = 2'b11;
    do_arm();
    have_b = 1'b1;
    c = ecount;
    expect_rec(1'b1, c + QUAL, 4);
    tick(QUAL + 3);
    chk("abort_pre_addr", int'(wr_addr), 3);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    have_b = 1'b0;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ch", int'(cap_ch), 1);
    tick(2);
    chk("abort_no_done", int'(cap_done), 0);
    capture(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);

    // ARM held through capture and done does not restart.
    capture(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset at write 5 of a B record.
    ch_en = 2'b10;
    do_arm();
    have_b = 1'b1;
    c = ecount;
    expect_rec(1'b1, c + QUAL, 6);
    tick(QUAL + 5);
    chk("pre_reset_addr", int'(wr_addr), 5);
    have_b = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_addr", int'(wr_addr), 0);
    chk("mid_rst_data", int'(wr_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(cap_done), 0);
    chk("mid_rst_ch", int'(cap_ch), 0);
    tick(1);
    capture(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);

    tick(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
